// File: rtl/phy_sched_pkg.sv
// Shared defaults, FSM state type and counter-width helper for the PHY
// transmit scheduler.
package phy_sched_pkg;
  localparam int N_REQ_DEF       = 4;
  localparam int DATA_W_DEF      = 32;
  localparam int SLOT_CYCLES_DEF = 16;

  function automatic int cnt_w(input int slots);
    return $clog2(slots);
  endfunction

  localparam int CNT_W = cnt_w(SLOT_CYCLES_DEF);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
endpackage

// File: rtl/phy_tx_scheduler_if.sv
// Requester/PHY-side bundle of the transmit scheduler. master = requesters and
// PHY sink, slave = the scheduler itself.
interface phy_tx_scheduler_if
  import phy_sched_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic                    en;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ack;
  logic                    valid_out;
  logic [DATA_W-1:0]       Data_out;
  logic [ID_W-1:0]         grant_id;
  logic                    slot_start;

  modport master (
    output en, req_valid, req_data,
    input  req_ack, valid_out, Data_out, grant_id, slot_start
  );

  modport slave (
    input  en, req_valid, req_data,
    output req_ack, valid_out, Data_out, grant_id, slot_start
  );
endinterface

// File: rtl/phy_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr_i, with wrap.
module phy_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             found_o,
  output logic [ID_W-1:0]  win_o
);
  int              idx;
  logic [ID_W-1:0] idx_l;

  // Walk from the farthest offset down so the nearest one to ptr_i is the
  // last assignment and therefore wins.
  always_comb begin
    found_o = 1'b0;
    win_o   = '0;
    idx     = 0;
    idx_l   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_l = ID_W'(idx);
      if (req_i[idx_l]) begin
        found_o = 1'b1;
        win_o   = idx_l;
      end
    end
  end
endmodule

// File: rtl/phy_tx_scheduler.sv
// Shares one PHY transmit port among N_REQ sources: one round-robin grant per
// fixed slot of SLOT_CYCLES clocks, word held on Data_out for the whole slot.
module phy_tx_scheduler
  import phy_sched_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF
) (
  input logic               clk_32f,
  input logic               reset,
  phy_tx_scheduler_if.slave bus
);
  localparam int            CW       = cnt_w(SLOT_CYCLES);
  localparam int            ID_W     = $clog2(N_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [DATA_W-1:0]             hold_q, hold_d;
  logic [ID_W-1:0]               gid_q, gid_d, ptr_q, ptr_d, win;
  logic                          slot_start_q, found, boundary, grant;
  logic [N_REQ-1:0][DATA_W-1:0]  req_word;

  assign req_word = bus.req_data;
  assign boundary = (cnt_q == CNT_LAST);
  assign grant    = boundary && bus.en && found;

  phy_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .found_o (found),
    .win_o   (win)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Every boundary re-decides the next slot from scratch, whatever the state.
  always_comb begin
    state_d = state_q;
    if (boundary) state_d = grant ? SEND : IDLE;
  end

  always_comb begin
    bus.valid_out = (state_q == SEND);
    bus.Data_out  = (state_q == SEND) ? hold_q : '0;
  end

  // Ack is decoded from the registered slot counter, so it can only be high
  // in the boundary cycle and only for the single winner.
  for (genvar i = 0; i < N_REQ; i++) begin : g_ack
    assign bus.req_ack[i] = grant && (win == ID_W'(i));
  end

  always_comb begin
    cnt_d  = boundary ? '0 : cnt_q + CW'(1);
    hold_d = hold_q;
    gid_d  = gid_q;
    ptr_d  = ptr_q;
    if (grant) begin
      hold_d = req_word[win];
      gid_d  = win;
      ptr_d  = (win == ID_LAST) ? '0 : win + ID_W'(1);
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      hold_q       <= '0;
      gid_q        <= '0;
      ptr_q        <= '0;
      slot_start_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      gid_q        <= gid_d;
      ptr_q        <= ptr_d;
      slot_start_q <= boundary;
    end
  end

  assign bus.grant_id   = gid_q;
  assign bus.slot_start = slot_start_q;
endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Bench for phy_tx_scheduler: slot-level reference model (cycle count, rr
// pointer, expected slot contents) checked every cycle by scenario tasks.
module tb_phy_tx_scheduler;
  import phy_sched_pkg::*;

  localparam int N = 4, DW = 32, SLOT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  phy_tx_scheduler_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  phy_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .SLOT_CYCLES(SLOT)) dut (
    .clk_32f (clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  int            n_cmp = 0, n_bad = 0;
  int            m_cyc, m_ptr;
  logic          m_valid, m_ss;
  logic [DW-1:0] m_data;
  logic [1:0]    m_gid;
  bit            drop_on_ack;

  // Reference: winner = first pending requester at or after m_ptr, wrapping.
  function automatic int pick_model();
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (bus.req_valid[i[1:0]]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ack();
    int w = pick_model();
    exp_ack = '0;
    if ((m_cyc % SLOT) == SLOT - 1 && bus.en && w >= 0) exp_ack[w[1:0]] = 1'b1;
  endfunction

  task automatic set_word(input int i, input logic [DW-1:0] v);
    bus.req_data[i*DW +: DW] = v;
  endtask

  task automatic model_clear();
    m_cyc = 0; m_ptr = 0; m_valid = 1'b0; m_data = '0; m_gid = '0; m_ss = 1'b0;
  endtask

  task automatic do_reset();
    bus.en = 1'b1; bus.req_valid = '0; bus.req_data = '0; drop_on_ack = 0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Advance one clock and apply the slot rules to the model.
  task automatic tick();
    int            w;
    logic [N-1:0]  a;
    logic [DW-1:0] wd;
    w  = pick_model();
    a  = exp_ack();
    wd = (w >= 0) ? bus.req_data[w*DW +: DW] : '0;
    @(posedge clk);
    m_ss = 1'b0;
    if ((m_cyc % SLOT) == SLOT - 1) begin
      m_ss = 1'b1;
      if (a != '0) begin
        m_valid = 1'b1; m_data = wd; m_gid = w[1:0]; m_ptr = (w + 1) % N;
      end else begin
        m_valid = 1'b0; m_data = '0;
      end
    end
    m_cyc++;
    @(negedge clk);
    if (drop_on_ack && a != '0) bus.req_valid[w[1:0]] = 1'b0;
  endtask

  task automatic test_reset();
    bus.en = 1'b1; bus.req_valid = '1; bus.req_data = {$urandom, $urandom, $urandom, $urandom};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp += 5;
    if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL reset.valid got %b want 0", bus.valid_out); end
    if (bus.Data_out !== '0) begin n_bad++; $display("FAIL reset.data got %h want 0", bus.Data_out); end
    if (bus.req_ack !== '0) begin n_bad++; $display("FAIL reset.ack got %b want 0", bus.req_ack); end
    if (bus.grant_id !== '0) begin n_bad++; $display("FAIL reset.gid got %0d want 0", bus.grant_id); end
    if (bus.slot_start !== 1'b0) begin n_bad++; $display("FAIL reset.slot_start got %b want 0", bus.slot_start); end
  endtask

  task automatic test_single();
    logic [N-1:0] ea;
    do_reset();
    bus.req_valid = 4'b0001; set_word(0, 32'hFFFF_FFFF); drop_on_ack = 1;
    for (int c = 0; c < 40; c++) begin
      #1; ea = exp_ack(); n_cmp += 3;
      if (bus.valid_out !== m_valid) begin n_bad++; $display("FAIL single.valid c=%0d got %b want %b", c, bus.valid_out, m_valid); end
      if (bus.Data_out !== m_data) begin n_bad++; $display("FAIL single.data c=%0d got %h want %h", c, bus.Data_out, m_data); end
      if (bus.req_ack !== ea) begin n_bad++; $display("FAIL single.ack c=%0d got %b want %b", c, bus.req_ack, ea); end
      if (c == 15) begin
        n_cmp++;
        if (bus.req_ack !== 4'b0001) begin n_bad++; $display("FAIL single.first_ack got %b want 0001", bus.req_ack); end
      end
      tick();
    end
  endtask

  task automatic test_all_four();
    logic [N-1:0] ea;
    do_reset();
    set_word(0, 32'hEEEE_EEEE); set_word(1, 32'hDDDD_DDDD);
    set_word(2, 32'hCCCC_CCCC); set_word(3, 32'h0000_0003);
    bus.req_valid = 4'b1111; drop_on_ack = 1;
    for (int c = 0; c < SLOT * 5 + 4; c++) begin
      #1; ea = exp_ack(); n_cmp += 4;
      if (bus.valid_out !== m_valid) begin n_bad++; $display("FAIL all4.valid c=%0d got %b want %b", c, bus.valid_out, m_valid); end
      if (bus.Data_out !== m_data) begin n_bad++; $display("FAIL all4.data c=%0d got %h want %h", c, bus.Data_out, m_data); end
      if (bus.req_ack !== ea) begin n_bad++; $display("FAIL all4.ack c=%0d got %b want %b", c, bus.req_ack, ea); end
      if (bus.slot_start !== m_ss) begin n_bad++; $display("FAIL all4.slot_start c=%0d got %b want %b", c, bus.slot_start, m_ss); end
      if (c >= SLOT && c < SLOT * 5 && (c % SLOT) == 0) begin
        n_cmp++;
        if (bus.grant_id !== 2'(c / SLOT - 1)) begin n_bad++; $display("FAIL all4.order c=%0d got %0d want %0d", c, bus.grant_id, c / SLOT - 1); end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] ea;
    do_reset();
    set_word(0, 32'hAAAA_AAAA); set_word(2, 32'h9999_9999);
    bus.req_valid = 4'b0101;
    for (int c = 0; c < SLOT * 5; c++) begin
      #1; ea = exp_ack(); n_cmp += 4;
      if (bus.req_ack !== ea) begin n_bad++; $display("FAIL fair.ack c=%0d got %b want %b", c, bus.req_ack, ea); end
      if ((bus.req_ack & 4'b1010) !== 4'b0000) begin n_bad++; $display("FAIL fair.idle_req c=%0d got %b want 0000", c, bus.req_ack & 4'b1010); end
      if (bus.Data_out !== m_data) begin n_bad++; $display("FAIL fair.data c=%0d got %h want %h", c, bus.Data_out, m_data); end
      if (bus.grant_id !== m_gid) begin n_bad++; $display("FAIL fair.gid c=%0d got %0d want %0d", c, bus.grant_id, m_gid); end
      tick();
    end
  endtask

  task automatic test_enable();
    logic [N-1:0] ea;
    do_reset();
    set_word(1, 32'h0000_0007); bus.req_valid = 4'b0010; drop_on_ack = 1;
    for (int c = 0; c < 52; c++) begin
      bus.en = (c == 15) ? 1'b0 : (c == 31) ? 1'b1 : 1'($urandom_range(0, 1));
      #1; ea = exp_ack(); n_cmp += 4;
      if (bus.valid_out !== m_valid) begin n_bad++; $display("FAIL en.valid c=%0d got %b want %b", c, bus.valid_out, m_valid); end
      if (bus.Data_out !== m_data) begin n_bad++; $display("FAIL en.data c=%0d got %h want %h", c, bus.Data_out, m_data); end
      if (bus.req_ack !== ea) begin n_bad++; $display("FAIL en.ack c=%0d got %b want %b", c, bus.req_ack, ea); end
      if (bus.grant_id !== m_gid) begin n_bad++; $display("FAIL en.gid c=%0d got %0d want %0d", c, bus.grant_id, m_gid); end
      tick();
    end
  endtask

  task automatic test_midslot();
    logic [N-1:0] ea;
    do_reset();
    drop_on_ack = 1; set_word(3, $urandom);
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin bus.req_valid[3] = 1'b1; set_word(3, 32'h0000_0008); end
      #1; ea = exp_ack(); n_cmp += 3;
      if (bus.req_ack !== ea) begin n_bad++; $display("FAIL mid.ack c=%0d got %b want %b", c, bus.req_ack, ea); end
      if (bus.valid_out !== m_valid) begin n_bad++; $display("FAIL mid.valid c=%0d got %b want %b", c, bus.valid_out, m_valid); end
      if (bus.Data_out !== m_data) begin n_bad++; $display("FAIL mid.data c=%0d got %h want %h", c, bus.Data_out, m_data); end
      tick();
    end
  endtask

  task automatic test_reset_midslot();
    logic [N-1:0] ea;
    do_reset();
    set_word(0, 32'h1111_1111); set_word(1, 32'h2222_2222); bus.req_valid = 4'b0011;
    for (int c = 0; c < SLOT + 7; c++) begin
      #1; n_cmp++;
      if (bus.Data_out !== m_data) begin n_bad++; $display("FAIL rstmid.pre_data c=%0d got %h want %h", c, bus.Data_out, m_data); end
      tick();
    end
    #2 rst_n = 1'b0;
    #1; n_cmp += 3;
    if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL rstmid.valid got %b want 0", bus.valid_out); end
    if (bus.Data_out !== '0) begin n_bad++; $display("FAIL rstmid.data got %h want 0", bus.Data_out); end
    if (bus.req_ack !== '0) begin n_bad++; $display("FAIL rstmid.ack got %b want 0", bus.req_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int c = 0; c < 24; c++) begin
      #1; ea = exp_ack(); n_cmp += 2;
      if (bus.req_ack !== ea) begin n_bad++; $display("FAIL rstmid.ack c=%0d got %b want %b", c, bus.req_ack, ea); end
      if (bus.Data_out !== m_data) begin n_bad++; $display("FAIL rstmid.data c=%0d got %h want %h", c, bus.Data_out, m_data); end
      if (c == 15) begin
        n_cmp++;
        if (bus.req_ack !== 4'b0001) begin n_bad++; $display("FAIL rstmid.ptr0 got %b want 0001", bus.req_ack); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ea;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) bus.req_valid[i[1:0]] = ~bus.req_valid[i[1:0]];
        if ($urandom_range(0, 7) == 0) set_word(i, $urandom);
      end
      bus.en = ($urandom_range(0, 5) != 0);
      #1; ea = exp_ack(); n_cmp += 5;
      if (bus.valid_out !== m_valid) begin n_bad++; $display("FAIL rand.valid c=%0d got %b want %b", c, bus.valid_out, m_valid); end
      if (bus.Data_out !== m_data) begin n_bad++; $display("FAIL rand.data c=%0d got %h want %h", c, bus.Data_out, m_data); end
      if (bus.req_ack !== ea) begin n_bad++; $display("FAIL rand.ack c=%0d got %b want %b", c, bus.req_ack, ea); end
      if (bus.grant_id !== m_gid) begin n_bad++; $display("FAIL rand.gid c=%0d got %0d want %0d", c, bus.grant_id, m_gid); end
      if (bus.slot_start !== m_ss) begin n_bad++; $display("FAIL rand.slot_start c=%0d got %b want %b", c, bus.slot_start, m_ss); end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    drop_on_ack = 0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_enable();
    test_midslot();
    test_reset_midslot();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
